mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-port memory between two bus masters: M0, the Processor memory port, and M1, a program loader / debug port. It handles the Processor-style level handshake (Read/Write held until Ready) on each master side. It drives a single memory-side strobe interface, handles memory wait states via iMemRdy, and aborts hung accesses with a timeout. It sits between the Processor and the unified instruction/data memory in system and lab top levels, replacing the ad-hoc bench memory decoding.

## Interface
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- TIMEOUT, 16, max BUSY cycles without iMemRdy before abort (≥1)
- iClk  in  1  clock, all logic on rising edge
- nRst  in  1  reset; synchronous, active-low
- iM0Addr / iM1Addr  in  ADDR_W  master address
- iM0Data / iM1Data  in  DATA_W  master write data
- iM0Read / iM1Read  in  1  read request, level, held until Rdy
- iM0Write / iM1Write  in  1  write request, level, held until Rdy
- oM0Data / oM1Data  out  DATA_W  read data, valid with Rdy, held until next read completion on that master
- oM0Rdy / oM1Rdy  out  1  one-cycle completion pulse
- oM0Err / oM1Err  out  1  one-cycle timeout flag, coincident with Rdy
- oMemAddr  out  ADDR_W  registered address to memory
- oMemData  out  DATA_W  registered write data to memory
- oMemRead / oMemWrite  out  1  memory strobes
- iMemData  in  DATA_W  memory read data
- iMemRdy  in  1  memory completion, sampled only in BUSY
- oGrant  out  2  one-hot current owner (01=M0, 10=M1, 00=none)

## Operation
- States: IDLE, BUSY, DONE.
- Request for Mx = iMxRead | iMxWrite. If both Read and Write are set, the access is a write.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesting: grant the master not served last. The last-served pointer resets to M1, so M0 wins the first tie.
  - On grant, register addr, wdata and op into oMemAddr, oMemData, and the op flag, set oGrant, clear the timeout counter, and go to BUSY.
- BUSY:
  - oMemRead or oMemWrite is high per the registered op. Address and data stay stable.
  - iMemRdy=1: latch iMemData into oMxData (reads only; writes leave oMxData unchanged), pulse oMxRdy, update the pointer, and go to DONE.
  - Else, if the counter equals TIMEOUT-1: pulse oMxRdy and oMxErr, set oMxData=0 (reads only), update the pointer, and go to DONE.
  - Else, increment the counter.
- DONE:
  - Strobes are low and oGrant=00.
  - Ignore all requests for one cycle so the master can drop its request, then go to IDLE.
- Master-side inputs are sampled only in IDLE. Changes during BUSY/DONE are ignored.

## Timing
- Reset (nRst=0 at an edge) sets:
  - state=IDLE, pointer=M1, counter=0;
  - all outputs 0: oMemAddr, oMemData, oMemRead, oMemWrite, oGrant, oMxData, oMxRdy, oMxErr.
- Reset applies mid-transaction too. The in-flight access is dropped with no Rdy. A still-held request is re-arbitrated normally after release.
- Request present in IDLE during cycle N:
  - strobes and oGrant high in cycle N+1;
  - with iMemRdy=1 in N+1, oMxRdy high in N+2 (DONE);
  - earliest next grant is evaluated in N+3.
- Zero-wait-state throughput: one access per 3 cycles.
- Each wait state (iMemRdy=0 in BUSY) adds one cycle. Strobes stay high for exactly the number of BUSY cycles.
- Timeout: strobes are high for TIMEOUT cycles, then Rdy+Err appear in the following cycle.
- iMemRdy arriving on the same cycle as the timeout limit: treat as success. Rdy wins and Err stays 0.
- oMxRdy/oMxErr are never high for more than one cycle, and never on both masters in the same cycle.

## Test plan
- M0 read addr 0x14, memory returns 0x22 with iMemRdy=1 immediately:
  - oMemRead high exactly 1 cycle;
  - oM0Rdy pulse 2 cycles after the request;
  - oM0Data=0x22, oM1Rdy never asserted.
- M0 write addr 0x17 data 0x20 and M1 read addr 0x15 raised together after reset:
  - oGrant sequence 01, 00, 10;
  - write strobe with addr 0x17 / data 0x20 first, then read of 0x15.
- Both masters hold requests continuously for 4 transactions: grants alternate M0, M1, M0, M1, each separated by one DONE cycle.
- M1 read with iMemRdy delayed 3 cycles:
  - oMemRead high 3 cycles, oMemAddr constant;
  - oM1Rdy in the 4th cycle after grant.
- TIMEOUT=4, M0 read, iMemRdy held 0:
  - oMemRead high 4 cycles, then oM0Rdy=oM0Err=1 for one cycle;
  - oM0Data=0, arbiter returns to IDLE.
- nRst pulsed low during BUSY of an M1 write:
  - next edge: all outputs 0, no Rdy;
  - after release, the still-held M1 request is re-granted and completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for one single-port memory: level-handshake masters,
// strobe-style memory side with wait states and a hung-access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] iM0Addr,
  input  logic [DATA_W-1:0] iM0Data,
  input  logic              iM0Read,
  input  logic              iM0Write,
  output logic [DATA_W-1:0] oM0Data,
  output logic              oM0Rdy,
  output logic              oM0Err,
  input  logic [ADDR_W-1:0] iM1Addr,
  input  logic [DATA_W-1:0] iM1Data,
  input  logic              iM1Read,
  input  logic              iM1Write,
  output logic [DATA_W-1:0] oM1Data,
  output logic              oM1Rdy,
  output logic              oM1Err,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  output logic              oMemRead,
  output logic              oMemWrite,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemRdy,
  output logic [1:0]        oGrant
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, nxt_state;
  logic             owner;      // 0 = M0, 1 = M1
  logic             last_m1;    // last-served pointer
  logic             op_write;
  logic [CNT_W-1:0] cnt;
  logic             req0, req1, grant_m1, timeout_hit;

  always_comb begin
    req0        = iM0Read | iM0Write;
    req1        = iM1Read | iM1Write;
    grant_m1    = (req0 && req1) ? ~last_m1 : req1;
    timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
    nxt_state   = state;
    case (state)
      IDLE:    if (req0 || req1) nxt_state = BUSY;
      BUSY:    if (iMemRdy || timeout_hit) nxt_state = DONE;
      DONE:    nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!nRst) state <= IDLE;
    else       state <= nxt_state;
  end

  always_ff @(posedge iClk) begin
    if (!nRst) begin
      owner    <= 1'b0;
      last_m1  <= 1'b1;
      op_write <= 1'b0;
      cnt      <= '0;
      oMemAddr <= '0;
      oMemData <= '0;
      oM0Data  <= '0;
      oM1Data  <= '0;
      oM0Rdy   <= 1'b0;
      oM1Rdy   <= 1'b0;
      oM0Err   <= 1'b0;
      oM1Err   <= 1'b0;
    end else begin
      oM0Rdy <= 1'b0;
      oM1Rdy <= 1'b0;
      oM0Err <= 1'b0;
      oM1Err <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          owner    <= grant_m1;
          oMemAddr <= grant_m1 ? iM1Addr : iM0Addr;
          oMemData <= grant_m1 ? iM1Data : iM0Data;
          op_write <= grant_m1 ? iM1Write : iM0Write;
          cnt      <= '0;
        end
        BUSY: begin
          // A memory response on the limit cycle still counts as success.
          if (iMemRdy || timeout_hit) begin
            last_m1 <= owner;
            if (owner) begin
              oM1Rdy <= 1'b1;
              oM1Err <= ~iMemRdy;
              if (!op_write) oM1Data <= iMemRdy ? iMemData : '0;
            end else begin
              oM0Rdy <= 1'b1;
              oM0Err <= ~iMemRdy;
              if (!op_write) oM0Data <= iMemRdy ? iMemData : '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    oMemRead  = (state == BUSY) && !op_write;
    oMemWrite = (state == BUSY) && op_write;
    oGrant    = (state == BUSY) ? {owner, ~owner} : 2'b00;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model:
// round-robin pick, wait-state/timeout outcome and a small memory array.
module tb_mem_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_rdy, m1_rdy, m0_err, m1_err;
  logic [31:0] mem_addr, mem_wdat, mem_dat;
  logic        mem_rd, mem_wr, mem_rdy;
  logic [1:0]  grant;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .iClk(clk), .nRst(nrst),
    .iM0Addr(m0_addr), .iM0Data(m0_wdat), .iM0Read(m0_rd), .iM0Write(m0_wr),
    .oM0Data(m0_rdat), .oM0Rdy(m0_rdy), .oM0Err(m0_err),
    .iM1Addr(m1_addr), .iM1Data(m1_wdat), .iM1Read(m1_rd), .iM1Write(m1_wr),
    .oM1Data(m1_rdat), .oM1Rdy(m1_rdy), .oM1Err(m1_err),
    .oMemAddr(mem_addr), .oMemData(mem_wdat), .oMemRead(mem_rd), .oMemWrite(mem_wr),
    .iMemData(mem_dat), .iMemRdy(mem_rdy), .oGrant(grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem_m [16];
  bit          req_v [2];
  bit          drv_rd [2];
  bit          drv_wr [2];
  logic [31:0] req_a [2];
  logic [31:0] req_d [2];
  logic [31:0] hold_d [2];
  int          last_served;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic put(input int m, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wdat = d;
    end else begin
      m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wdat = d;
    end
  endtask

  task automatic apply_inputs();
    for (int m = 0; m < 2; m++) begin
      if (req_v[m]) put(m, drv_rd[m], drv_wr[m], req_a[m], req_d[m]);
      else          put(m, 1'b0, 1'b0, $urandom, $urandom);
    end
  endtask

  task automatic new_req(input int m, input int op);
    req_v[m]  = 1'b1;
    drv_rd[m] = (op != 1);
    drv_wr[m] = (op != 0);
    req_a[m]  = $urandom;
    req_d[m]  = $urandom;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_strobe"}, {mem_wr, mem_rd}, 2'b00);
    check({tag, "_rdy"}, {m1_rdy, m0_rdy}, 2'b00);
  endtask

  // Called at the negedge of the IDLE cycle in which master m is picked.
  task automatic serve(input int m, input int wait_n);
    int  b;
    bit  ok, to;
    logic [31:0] rdat;
    b = 0; ok = 0; to = 0; rdat = '0;
    @(negedge clk);
    while (!(ok || to)) begin
      check("busy_grant", grant, (m == 1) ? 2'b10 : 2'b01);
      check("busy_rd", mem_rd, !drv_wr[m]);
      check("busy_wr", mem_wr, drv_wr[m]);
      check("busy_addr", mem_addr, req_a[m]);
      check("busy_wdata", mem_wdat, req_d[m]);
      check("busy_rdy", {m1_rdy, m0_rdy, m1_err, m0_err}, 4'b0000);
      put(m, drv_rd[m], drv_wr[m], $urandom, $urandom);
      ok      = (b == wait_n);
      to      = !ok && (b == TO - 1);
      mem_rdy = ok;
      rdat    = mem_m[req_a[m][3:0]];
      mem_dat = ok ? rdat : $urandom;
      @(negedge clk);
      b++;
    end
    mem_rdy = 1'b0;
    if (!drv_wr[m]) hold_d[m] = ok ? rdat : 32'h0;
    else if (ok)    mem_m[req_a[m][3:0]] = req_d[m];
    check("done_rdy", {m1_rdy, m0_rdy}, (m == 1) ? 2'b10 : 2'b01);
    check("done_err", {m1_err, m0_err}, to ? ((m == 1) ? 2'b10 : 2'b01) : 2'b00);
    check("done_m0data", m0_rdat, hold_d[0]);
    check("done_m1data", m1_rdat, hold_d[1]);
    check("done_grant", grant, 2'b00);
    check("done_strobe", {mem_wr, mem_rd}, 2'b00);
    last_served = m;
    if ($urandom_range(0, 1) == 1) new_req(m, $urandom_range(0, 2));
    else                           req_v[m] = 1'b0;
    apply_inputs();
    @(negedge clk);
    check_quiet("idle");
    check("idle_err", {m1_err, m0_err}, 2'b00);
  endtask

  initial begin
    int pick;
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    req_v[0] = 0; req_v[1] = 0;
    hold_d[0] = '0; hold_d[1] = '0;
    last_served = 1;
    nrst = 1'b0; mem_rdy = 1'b0; mem_dat = '0;
    put(0, 0, 0, '0, '0);
    put(1, 0, 0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    check("rst_err", {m1_err, m0_err}, 2'b00);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdat, 32'h0);
    check("rst_m0data", m0_rdat, 32'h0);
    check("rst_m1data", m1_rdat, 32'h0);
    nrst = 1'b1;

    // First tie after reset goes to M0.
    new_req(0, 1);
    new_req(1, 0);
    apply_inputs();
    serve(0, 0);

    for (int slot = 0; slot < 300; slot++) begin
      for (int m = 0; m < 2; m++)
        if (!req_v[m] && $urandom_range(0, 2) != 0) new_req(m, $urandom_range(0, 2));
      apply_inputs();
      if (!req_v[0] && !req_v[1]) begin
        @(negedge clk);
        check_quiet("noreq");
      end else begin
        if (req_v[0] && req_v[1]) pick = (last_served == 1) ? 0 : 1;
        else                      pick = req_v[1] ? 1 : 0;
        serve(pick, $urandom_range(0, 5));
      end
    end

    // Reset in the middle of an M1 write; the held request is served afterwards.
    req_v[0] = 0;
    new_req(1, 1);
    apply_inputs();
    @(negedge clk);
    check("mid_grant", grant, 2'b10);
    check("mid_wr", mem_wr, 1'b1);
    nrst = 1'b0;
    @(negedge clk);
    hold_d[0] = '0; hold_d[1] = '0;
    last_served = 1;
    check_quiet("midrst");
    check("midrst_err", {m1_err, m0_err}, 2'b00);
    check("midrst_addr", mem_addr, 32'h0);
    check("midrst_wdata", mem_wdat, 32'h0);
    check("midrst_m0data", m0_rdat, 32'h0);
    check("midrst_m1data", m1_rdat, 32'h0);
    nrst = 1'b1;
    serve(1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
